// File: rtl/banked_scratchpad_pkg.sv
// banked_scratchpad_pkg: shared constants and sizing helpers for the banked scratchpad
package banked_scratchpad_pkg;
    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    function automatic int bank_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int byte_lanes(input int w);
        return w / 8;
    endfunction

    function automatic int slice_lo(input int p, input int w);
        return p * w;
    endfunction
endpackage

// File: rtl/banked_scratchpad_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, pointer moves past the winner when advance is set
module rr_arbiter
    import banked_scratchpad_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = bank_bits(N);

    logic [PW-1:0] ptr_q, ptr_d, win;
    logic          found;

    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr_q) + i) % N]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + i) % N);
            end
        end
        gnt[win] = found;
        ptr_d    = (advance && found) ? PW'((int'(win) + 1) % N) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/banked_scratchpad.sv
// banked_scratchpad: multi-port, low-order interleaved, round-robin arbitrated scratchpad
module banked_scratchpad
    import banked_scratchpad_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int DATA_W    = 32,
    parameter int NUM_BANKS = 4,
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BE_W      = byte_lanes(DATA_W)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_rd_nwr,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS*BE_W-1:0]     req_be,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [NUM_PORTS*DATA_W-1:0]   rsp_rdata
);
    localparam int BANK_W = bank_bits(NUM_BANKS);
    localparam int ROWS   = DEPTH / NUM_BANKS;
    localparam int ROW_W  = ADDR_W - BANK_W;

    logic [ADDR_W-1:0]           addr      [NUM_PORTS];
    logic [DATA_W-1:0]           wdata     [NUM_PORTS];
    logic [BE_W-1:0]             be        [NUM_PORTS];
    logic [BANK_W-1:0]           bank_of   [NUM_PORTS];
    logic [NUM_PORTS-1:0]        gnt_all   [NUM_BANKS];
    logic [DATA_W-1:0]           bank_rdata[NUM_BANKS];
    logic [NUM_PORTS-1:0]        rsp_valid_d, rsp_valid_q;
    logic [NUM_PORTS*DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign addr[p]    = req_addr[slice_lo(p, ADDR_W) +: ADDR_W];
        assign wdata[p]   = req_wdata[slice_lo(p, DATA_W) +: DATA_W];
        assign be[p]      = req_be[slice_lo(p, BE_W) +: BE_W];
        assign bank_of[p] = addr[p][BANK_W-1:0];
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_PORTS-1:0] cand, gnt;
        logic [ROW_W-1:0]     row;
        logic [DATA_W-1:0]    wd;
        logic [BE_W-1:0]      bm;
        logic                 rd;
        logic [DATA_W-1:0]    mem [ROWS];

        always_comb begin
            cand = '0;
            for (int i = 0; i < NUM_PORTS; i++)
                cand[i] = req_valid[i] && (bank_of[i] == BANK_W'(b));
        end

        rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (cand),
            .advance (|cand),
            .gnt     (gnt)
        );

        always_comb begin
            row = '0;
            wd  = '0;
            bm  = '0;
            rd  = RD;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt[i]) begin
                    row = addr[i][ADDR_W-1:BANK_W];
                    wd  = wdata[i];
                    bm  = be[i];
                    rd  = req_rd_nwr[i];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (|gnt && rd == WR)
                for (int i = 0; i < BE_W; i++)
                    if (bm[i]) mem[row][8*i +: 8] <= wd[8*i +: 8];
        end

        assign bank_rdata[b] = mem[row];
        assign gnt_all[b]    = gnt;
    end

    always_comb begin
        req_ready   = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_ready[i]   = gnt_all[bank_of[i]][i];
            rsp_valid_d[i] = req_ready[i] && (req_rd_nwr[i] == RD);
            if (rsp_valid_d[i])
                rsp_rdata_d[slice_lo(i, DATA_W) +: DATA_W] = bank_rdata[bank_of[i]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_banked_scratchpad.sv
// tb_banked_scratchpad: directed and random stimulus against a behavioural scratchpad model
module tb_banked_scratchpad;
    localparam int NP = 2, DW = 32, NB = 4, DEPTH = 64, AW = 6, BEW = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    req_valid, req_ready, req_rd_nwr, rsp_valid;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata, rsp_rdata;
    logic [NP*BEW-1:0] req_be;

    banked_scratchpad #(
        .DEPTH(DEPTH), .DATA_W(DW), .NUM_BANKS(NB), .NUM_PORTS(NP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd_nwr (req_rd_nwr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mm  [DEPTH];
    logic [DW-1:0] erd [NP];
    int            ptr [NB];
    int            win [NB];
    logic [NP-1:0] erv, eready, last_ready, acc;
    logic [NP-1:0] pat [4];
    int            tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int port_addr(input int p);
        return int'(req_addr[p*AW +: AW]);
    endfunction

    task automatic set_req(input int p, input logic v, input logic rd, input int a,
                           input logic [DW-1:0] d, input logic [BEW-1:0] m);
        req_valid[p]            = v;
        req_rd_nwr[p]           = rd;
        req_addr[p*AW +: AW]    = AW'(a);
        req_wdata[p*DW +: DW]   = d;
        req_be[p*BEW +: BEW]    = m;
    endtask

    task automatic model_reset();
        erv = '0;
        for (int p = 0; p < NP; p++) erd[p] = '0;
        for (int b = 0; b < NB; b++) ptr[b] = 0;
    endtask

    task automatic predict();
        eready = '0;
        for (int b = 0; b < NB; b++) begin
            win[b] = -1;
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (ptr[b] + k) % NP;
                if (win[b] < 0 && req_valid[p] && (port_addr(p) % NB) == b) begin
                    win[b]    = p;
                    eready[p] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        logic [NP-1:0] nrv;
        @(negedge clk);
        predict();
        last_ready = req_ready;
        chk("ready", 64'(req_ready), 64'(eready));
        for (int p = 0; p < NP; p++) begin
            chk("rsp_valid", 64'(rsp_valid[p]), 64'(erv[p]));
            chk("rsp_rdata", 64'(rsp_rdata[p*DW +: DW]), 64'(erd[p]));
        end
        acc = eready;
        nrv = '0;
        for (int p = 0; p < NP; p++)
            if (acc[p] && req_rd_nwr[p]) begin
                nrv[p] = 1'b1;
                erd[p] = mm[port_addr(p)];
            end
        for (int p = 0; p < NP; p++)
            if (acc[p] && !req_rd_nwr[p])
                for (int i = 0; i < BEW; i++)
                    if (req_be[p*BEW + i]) mm[port_addr(p)][8*i +: 8] = req_wdata[p*DW + 8*i +: 8];
        for (int b = 0; b < NB; b++)
            if (win[b] >= 0) ptr[b] = (win[b] + 1) % NP;
        erv = nrv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_valid = '0; req_rd_nwr = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        acc = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));

        for (int a = 0; a < DEPTH; a++) begin
            set_req(0, 1'b1, 1'b0, a, 32'($urandom), 4'hF);
            step();
        end
        req_valid = '0;

        set_req(0, 1'b1, 1'b0, 5, 32'hDEADBEEF, 4'hF);
        step();
        chk("basic_wr_ready", 64'(last_ready[0]), 64'(1));
        set_req(0, 1'b1, 1'b1, 5, 32'h0, 4'h0);
        step();
        req_valid = '0;
        chk("basic_rd_ready", 64'(last_ready[0]), 64'(1));
        chk("basic_rsp_valid", 64'(rsp_valid[0]), 64'(1));
        chk("basic_rdata", 64'(rsp_rdata[31:0]), 64'(32'hDEADBEEF));

        set_req(0, 1'b1, 1'b0, 2, 32'h11223344, 4'hF);
        step();
        set_req(0, 1'b1, 1'b0, 2, 32'hAABBCCDD, 4'h5);
        step();
        set_req(0, 1'b1, 1'b1, 2, 32'h0, 4'h0);
        step();
        req_valid = '0;
        chk("be_rsp_valid", 64'(rsp_valid[0]), 64'(1));
        chk("be_rdata", 64'(rsp_rdata[31:0]), 64'(32'h11BB33DD));

        set_req(0, 1'b1, 1'b1, 4, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b1, 5, 32'h0, 4'h0);
        step();
        req_valid = '0;
        chk("par_ready", 64'(last_ready), 64'(2'b11));
        chk("par_rsp_valid", 64'(rsp_valid), 64'(2'b11));
        chk("par_rdata1", 64'(rsp_rdata[63:32]), 64'(32'hDEADBEEF));
        step();

        set_req(0, 1'b1, 1'b1, 2, 32'h0, 4'h0);
        step();
        req_valid = '0;
        chk("rst_pre_valid", 64'(rsp_valid[0]), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 1'b1, 5, 32'h0, 4'h0);
        step();
        req_valid = '0;
        chk("rst_data_kept", 64'(rsp_rdata[31:0]), 64'(32'hDEADBEEF));

        set_req(0, 1'b1, 1'b1, 8, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b1, 12, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            pat[k] = last_ready;
        end
        req_valid = '0;
        chk("rr_grant0", 64'(pat[0]), 64'(2'b01));
        chk("rr_grant1", 64'(pat[1]), 64'(2'b10));
        chk("rr_grant2", 64'(pat[2]), 64'(2'b01));
        chk("rr_grant3", 64'(pat[3]), 64'(2'b10));
        step();

        set_req(0, 1'b1, 1'b1, 4, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 0, 32'hCAFEF00D, 4'hF);
        step();
        chk("bp_blocked", 64'(last_ready), 64'(2'b01));
        req_valid[0] = 1'b0;
        step();
        chk("bp_land", 64'(last_ready), 64'(2'b10));
        req_valid = '0;
        set_req(0, 1'b1, 1'b1, 0, 32'h0, 4'h0);
        step();
        req_valid = '0;
        chk("bp_rdata", 64'(rsp_rdata[31:0]), 64'(32'hCAFEF00D));

        acc = '0;
        repeat (3000) begin
            for (int p = 0; p < NP; p++)
                if (!req_valid[p] || acc[p])
                    set_req(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, DEPTH - 1)), 32'($urandom),
                            4'($urandom_range(0, 15)));
            step();
        end
        req_valid = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
